// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine transaction controller:
// FSM states, LCD status codes and coin values in cents.
package vend_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRICE,
      S_COLLECT,
      S_VEND,
      S_REFUND
   } state_e;

   localparam logic [2:0] STAT_IDLE        = 3'd0;
   localparam logic [2:0] STAT_RESERVED    = 3'd1;
   localparam logic [2:0] STAT_INSERT      = 3'd2;
   localparam logic [2:0] STAT_VEND_EXACT  = 3'd3;
   localparam logic [2:0] STAT_VEND_CHANGE = 3'd4;
   localparam logic [2:0] STAT_REFUND      = 3'd5;
   localparam logic [2:0] STAT_SOLDOUT     = 3'd6;
   localparam logic [2:0] STAT_INVALID     = 3'd7;

   localparam int unsigned COIN_NICKEL  = 5;
   localparam int unsigned COIN_DIME    = 10;
   localparam int unsigned COIN_QUARTER = 25;
   localparam int unsigned COIN_DOLLAR  = 100;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: registered history plus a registered one-cycle pulse,
// so a held level produces exactly one event.
module edge_pulse (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic pulse
);

   logic prev_q, prev_d;
   logic pulse_q, pulse_d;

   always_comb begin
      prev_d  = level;
      pulse_d = level & ~prev_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/vend_ctrl_multi.sv
// Vending-machine transaction controller: product select, price/stock tables,
// coin credit accumulation, vend with exact change, cancel/timeout refund.
module vend_ctrl_multi
   import vend_pkg::*;
#(
   parameter int                  N_PROD     = 4,
   parameter int                  AMT_W      = 10,
   parameter logic [16*N_PROD-1:0] PRICES    = {16'd150, 16'd125, 16'd100, 16'd50},
   parameter int                  STOCK_W    = 4,
   parameter int                  STOCK_INIT = 5,
   parameter int                  TIMEOUT    = 1000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        nickel,
   input  logic                        dime,
   input  logic                        quarter,
   input  logic                        dollar,
   input  logic                        cancel,
   input  logic [N_PROD-1:0]           select,
   input  logic                        restock,
   output logic                        dispense,
   output logic [$clog2(N_PROD)-1:0]   dispense_id,
   output logic                        change_valid,
   output logic [AMT_W-1:0]            change_amt,
   output logic [AMT_W-1:0]            credit,
   output logic [2:0]                  status,
   output logic                        busy
);

   localparam int ID_W  = $clog2(N_PROD);
   localparam int TM_W  = $clog2(TIMEOUT);
   localparam int SUM_W = AMT_W + 8;
   localparam logic [AMT_W-1:0] AMT_MAX = '1;

   logic [4:0] lvl;
   logic [4:0] ev;

   assign lvl = {cancel, dollar, quarter, dime, nickel};

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_edge
         edge_pulse u_edge (
            .clk   (clk),
            .rst   (rst),
            .level (lvl[gi]),
            .pulse (ev[gi])
         );
      end
   endgenerate

   logic [AMT_W-1:0] price_tbl [N_PROD];

   generate
      for (gi = 0; gi < N_PROD; gi++) begin : g_price
         assign price_tbl[gi] = PRICES[gi*16 +: AMT_W];
      end
   endgenerate

   state_e              state_q, state_d;
   logic [ID_W-1:0]     idx_q, idx_d;
   logic [AMT_W-1:0]    price_q, price_d;
   logic [AMT_W-1:0]    credit_q, credit_d;
   logic [TM_W-1:0]     timer_q, timer_d;
   logic [STOCK_W-1:0]  stock_q [N_PROD];
   logic [STOCK_W-1:0]  stock_d [N_PROD];
   logic                dispense_q, dispense_d;
   logic [ID_W-1:0]     dispense_id_q, dispense_id_d;
   logic                change_valid_q, change_valid_d;
   logic [AMT_W-1:0]    change_amt_q, change_amt_d;
   logic [2:0]          status_q, status_d;

   logic [ID_W-1:0]     sel_idx;
   logic                sel_multi;
   logic                sel_one;
   logic [SUM_W-1:0]    coin_sum;
   logic [SUM_W-1:0]    credit_sum;
   logic [AMT_W-1:0]    credit_sat;
   logic                coin_any;
   logic                cancel_ev;

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < N_PROD; i++) begin
         if (select[i]) sel_idx = ID_W'(i);
      end
   end

   // Clearing the lowest set bit leaves something only when two or more bits are set.
   assign sel_multi = (select & (select - N_PROD'(1))) != '0;
   assign sel_one   = (select != '0) && !sel_multi;

   assign coin_any  = |ev[3:0];
   assign cancel_ev = ev[4];

   assign coin_sum = (ev[0] ? SUM_W'(COIN_NICKEL)  : '0)
                   + (ev[1] ? SUM_W'(COIN_DIME)    : '0)
                   + (ev[2] ? SUM_W'(COIN_QUARTER) : '0)
                   + (ev[3] ? SUM_W'(COIN_DOLLAR)  : '0);

   assign credit_sum = SUM_W'(credit_q) + coin_sum;
   assign credit_sat = (credit_sum > SUM_W'(AMT_MAX)) ? AMT_MAX : credit_sum[AMT_W-1:0];

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      price_d        = price_q;
      credit_d       = credit_q;
      timer_d        = timer_q;
      stock_d        = stock_q;
      dispense_d     = 1'b0;
      dispense_id_d  = '0;
      change_valid_d = 1'b0;
      change_amt_d   = '0;
      status_d       = status_q;

      case (state_q)
         S_IDLE: begin
            if (restock) begin
               for (int i = 0; i < N_PROD; i++) stock_d[i] = STOCK_W'(STOCK_INIT);
            end
            if (sel_one) begin
               idx_d   = sel_idx;
               state_d = S_PRICE;
            end else if (sel_multi) begin
               status_d = STAT_INVALID;
            end else if (status_q == STAT_INVALID) begin
               status_d = STAT_IDLE;
            end
         end

         S_PRICE: begin
            if (stock_q[idx_q] == '0) begin
               status_d = STAT_SOLDOUT;
               state_d  = S_IDLE;
            end else begin
               price_d  = price_tbl[idx_q];
               credit_d = '0;
               timer_d  = '0;
               status_d = STAT_INSERT;
               state_d  = S_COLLECT;
            end
         end

         S_COLLECT: begin
            credit_d = credit_sat;
            timer_d  = coin_any ? '0 : timer_q + TM_W'(1);
            // Cancel/timeout wins over a same-cycle payment; those coins are refunded.
            if (cancel_ev || (timer_q == TM_W'(TIMEOUT - 1))) begin
               state_d = S_REFUND;
            end else if (credit_sat >= price_q) begin
               state_d = S_VEND;
            end
         end

         S_VEND: begin
            dispense_d       = 1'b1;
            dispense_id_d    = idx_q;
            stock_d[idx_q]   = stock_q[idx_q] - STOCK_W'(1);
            if (credit_q > price_q) begin
               change_valid_d = 1'b1;
               change_amt_d   = credit_q - price_q;
               status_d       = STAT_VEND_CHANGE;
            end else begin
               status_d       = STAT_VEND_EXACT;
            end
            credit_d = '0;
            state_d  = S_IDLE;
         end

         S_REFUND: begin
            if (credit_q != '0) begin
               change_valid_d = 1'b1;
               change_amt_d   = credit_q;
            end
            status_d = STAT_REFUND;
            credit_d = '0;
            state_d  = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         idx_q          <= '0;
         price_q        <= '0;
         credit_q       <= '0;
         timer_q        <= '0;
         dispense_q     <= 1'b0;
         dispense_id_q  <= '0;
         change_valid_q <= 1'b0;
         change_amt_q   <= '0;
         status_q       <= STAT_IDLE;
         for (int i = 0; i < N_PROD; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         price_q        <= price_d;
         credit_q       <= credit_d;
         timer_q        <= timer_d;
         dispense_q     <= dispense_d;
         dispense_id_q  <= dispense_id_d;
         change_valid_q <= change_valid_d;
         change_amt_q   <= change_amt_d;
         status_q       <= status_d;
         stock_q        <= stock_d;
      end
   end

   assign dispense     = dispense_q;
   assign dispense_id  = dispense_id_q;
   assign change_valid = change_valid_q;
   assign change_amt   = change_amt_q;
   assign credit       = credit_q;
   assign status       = status_q;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Scoreboard bench for vend_ctrl_multi: stimulus tasks push expected vend/change
// events computed from a transaction-level model; a monitor pops and compares.
module tb_vend_ctrl_multi;

   localparam int T     = 1000;
   localparam int SINIT = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic       nickel, dime, quarter, dollar, cancel, restock;
   logic [3:0] select;
   logic       dispense, change_valid, busy;
   logic [1:0] dispense_id;
   logic [9:0] change_amt, credit;
   logic [2:0] status;

   vend_ctrl_multi dut (
      .clk          (clk),
      .rst          (rst),
      .nickel       (nickel),
      .dime         (dime),
      .quarter      (quarter),
      .dollar       (dollar),
      .cancel       (cancel),
      .select       (select),
      .restock      (restock),
      .dispense     (dispense),
      .dispense_id  (dispense_id),
      .change_valid (change_valid),
      .change_amt   (change_amt),
      .credit       (credit),
      .status       (status),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int disp;
      int id;
      int cv;
      int amt;
      int st;
      int cy;
   } exp_t;

   exp_t       exp_q[$];
   logic [4:0] grp_q[$];     // bit4 = cancel, bits3:0 = {dollar,quarter,dime,nickel}
   int         n_vec = 0;
   int         n_err = 0;
   int         cancel_hold = 0;
   int         price_m [4] = '{50, 100, 125, 150};
   int         stock_m [4] = '{SINIT, SINIT, SINIT, SINIT};

   function automatic int coin_value(logic [3:0] m);
      int v = 0;
      if (m[0]) v += 5;
      if (m[1]) v += 10;
      if (m[2]) v += 25;
      if (m[3]) v += 100;
      return v;
   endfunction

   function automatic void push_exp(int d, int id, int cv, int amt, int st, int cy);
      exp_t x;
      x.disp = d; x.id = id; x.cv = cv; x.amt = amt; x.st = st; x.cy = cy;
      exp_q.push_back(x);
   endfunction

   task automatic chk(string name, int act, int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_to(int t);
      while (cyc < t) tick(1);
   endtask

   task automatic set_coins(logic [3:0] m);
      {dollar, quarter, dime, nickel} = m;
   endtask

   // Monitor: every vend/change pulse must match the oldest expected event.
   always @(negedge clk) begin
      exp_t x;
      if (dispense || change_valid) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got disp=%0b id=%0d cv=%0b amt=%0d st=%0d cyc=%0d, required no event",
                     dispense, dispense_id, change_valid, change_amt, status, cyc);
         end else begin
            x = exp_q.pop_front();
            if (int'(dispense) != x.disp || int'(dispense_id) != x.id || int'(change_valid) != x.cv ||
                int'(change_amt) != x.amt || int'(status) != x.st || cyc != x.cy) begin
               n_err++;
               $display("FAIL event: got disp=%0b id=%0d cv=%0b amt=%0d st=%0d cyc=%0d, required disp=%0d id=%0d cv=%0d amt=%0d st=%0d cyc=%0d",
                        dispense, dispense_id, change_valid, change_amt, status, cyc,
                        x.disp, x.id, x.cv, x.amt, x.st, x.cy);
            end else begin
               $display("txn ok: disp=%0d id=%0d cv=%0d amt=%0d st=%0d cyc=%0d",
                        x.disp, x.id, x.cv, x.amt, x.st, x.cy);
            end
         end
      end else begin
         n_vec++;
         if (dispense_id != '0 || change_amt != '0) begin
            n_err++;
            $display("FAIL idle_zero: got id=%0d amt=%0d, required 0/0 (cycle %0d)", dispense_id, change_amt, cyc);
         end
      end
   end

   // One purchase attempt on product p using the coin groups in grp_q.
   task automatic run_txn(int p);
      int c, e, cr, i;
      logic [3:0] m;
      bit cxl;
      c = cyc;
      select = '0;
      select[p] = 1'b1;
      tick(1);
      select = '0;
      tick(1);
      if (stock_m[p] == 0) begin
         chk("soldout_status", status, 6);
         chk("soldout_busy", busy, 0);
         return;
      end
      chk("insert_status", status, 2);
      chk("collect_busy", busy, 1);
      chk("collect_credit0", credit, 0);
      cr = 0;
      i  = 0;
      while (1) begin
         if (i < grp_q.size()) begin
            cxl = grp_q[i][4];
            m   = grp_q[i][3:0];
         end else begin
            cxl = 1'b1;
            m   = 4'b0;
         end
         e = cyc;
         cancel = cxl;
         set_coins(m);
         tick(1);
         set_coins(4'b0);
         cr = cr + coin_value(m);
         if (cr > 1023) cr = 1023;
         if (cxl) begin
            if (cr > 0) push_exp(0, 0, 1, cr, 5, e + 3);
            tick(cancel_hold);
            cancel = 1'b0;
            wait_to(e + 4);
            chk("refund_status", status, 5);
            chk("refund_credit", credit, 0);
            chk("refund_busy", busy, 0);
            return;
         end
         tick(1);
         chk("credit", credit, cr);
         if (cr >= price_m[p]) begin
            if (cr > price_m[p]) push_exp(1, p, 1, cr - price_m[p], 4, e + 3);
            else                 push_exp(1, p, 0, 0, 3, e + 3);
            stock_m[p]--;
            tick(2);
            chk("vend_status", status, (cr > price_m[p]) ? 4 : 3);
            chk("vend_credit", credit, 0);
            chk("vend_busy", busy, 0);
            return;
         end
         tick($urandom_range(0, 2));
         i++;
      end
   endtask

   task automatic run_timeout(int p, logic [3:0] m);
      int c, e, anchor, cr;
      c = cyc;
      select = '0;
      select[p] = 1'b1;
      tick(1);
      select = '0;
      tick(1);
      anchor = c + 2;
      cr = 0;
      if (m != 0) begin
         e = cyc;
         set_coins(m);
         tick(1);
         set_coins(4'b0);
         cr = coin_value(m);
         anchor = e + 2;
      end
      if (cr > 0) push_exp(0, 0, 1, cr, 5, anchor + T + 1);
      wait_to(anchor + T - 1);
      chk("to_wait_busy", busy, 1);
      chk("to_wait_credit", credit, cr);
      tick(1);
      chk("to_refund_busy", busy, 1);
      chk("to_refund_status", status, 2);
      tick(1);
      chk("to_done_status", status, 5);
      chk("to_done_busy", busy, 0);
      chk("to_done_credit", credit, 0);
   endtask

   task automatic invalid_sel(logic [3:0] m);
      select = m;
      tick(1);
      select = '0;
      chk("invalid_status", status, 7);
      chk("invalid_busy", busy, 0);
      tick(1);
      chk("invalid_clear", status, 0);
   endtask

   initial begin
      #(10 * 200000);
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p, n, r, k;
      logic [3:0] m;
      rst = 1'b1;
      set_coins(4'b0);
      cancel = 1'b0;
      restock = 1'b0;
      select = '0;
      tick(3);
      chk("rst_dispense", dispense, 0);
      chk("rst_change_valid", change_valid, 0);
      chk("rst_credit", credit, 0);
      chk("rst_status", status, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      tick(2);

      grp_q = '{5'b00100, 5'b00100};
      run_txn(0);
      grp_q = '{5'b01100, 5'b00100};
      run_txn(3);
      grp_q = '{5'b01000, 5'b01000};
      run_txn(2);
      grp_q = '{5'b00010, 5'b10000};
      cancel_hold = 9;
      run_txn(1);
      grp_q = '{5'b10000};
      cancel_hold = 2;
      run_txn(1);

      run_timeout(0, 4'b0001);
      run_timeout(1, 4'b0000);
      invalid_sel(4'b0011);

      grp_q = '{5'b00100, 5'b00100};
      while (stock_m[0] > 0) run_txn(0);
      run_txn(0);
      restock = 1'b1;
      tick(1);
      restock = 1'b0;
      stock_m = '{SINIT, SINIT, SINIT, SINIT};
      run_txn(0);

      select = 4'b0001;
      tick(1);
      select = '0;
      tick(1);
      set_coins(4'b0101);
      tick(1);
      set_coins(4'b0000);
      tick(1);
      chk("pre_rst_credit", credit, 30);
      rst = 1'b1;
      tick(1);
      chk("mid_rst_credit", credit, 0);
      chk("mid_rst_status", status, 0);
      chk("mid_rst_busy", busy, 0);
      tick(1);
      rst = 1'b0;
      stock_m = '{SINIT, SINIT, SINIT, SINIT};
      tick(1);

      repeat (80) begin
         r = $urandom_range(0, 19);
         if (r == 0) begin
            restock = 1'b1;
            tick(1);
            restock = 1'b0;
            stock_m = '{SINIT, SINIT, SINIT, SINIT};
         end else if (r == 1) begin
            do m = 4'($urandom_range(0, 15)); while ($countones(m) < 2);
            invalid_sel(m);
         end else begin
            p = $urandom_range(0, 3);
            n = $urandom_range(1, 8);
            grp_q.delete();
            repeat (n) grp_q.push_back({1'b0, 4'($urandom_range(1, 15))});
            if ($urandom_range(0, 4) == 0) begin
               k = $urandom_range(0, n - 1);
               grp_q[k][4] = 1'b1;
               if ($urandom_range(0, 1) == 1) grp_q[k][3:0] = 4'b0;
            end
            cancel_hold = $urandom_range(0, 4);
            run_txn(p);
         end
         tick($urandom_range(0, 2));
      end

      tick(10);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
